// File: rtl/pcs_tx_gearbox_if.sv
// Bus between the 64b/66b encoder and the TX gearbox: data/header in with valid,
// pause backpressure, gearboxed word and error flags out.
interface pcs_tx_gearbox_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] i_data;
  logic [HDR_WIDTH-1:0]  i_hdr;
  logic                  i_valid;
  logic                  o_pause;
  logic [DATA_WIDTH-1:0] o_gearbox_data;
  logic                  o_err_underflow;
  logic                  o_err_overrun;

  modport master (
    output i_data, i_hdr, i_valid,
    input  o_pause, o_gearbox_data, o_err_underflow, o_err_overrun
  );

  modport slave (
    input  i_data, i_hdr, i_valid,
    output o_pause, o_gearbox_data, o_err_underflow, o_err_overrun
  );
endinterface

// File: rtl/pcs_tx_gearbox.sv
// 66b -> 32b TX gearbox: each 33-cycle period packs 16 blocks plus one pause cycle.
// Define PCS_TX_GBX_ERR_FLAGS_EN to build the sticky underflow/overrun detectors.
module pcs_tx_gearbox #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned HDR_WIDTH  = 2
) (
  input logic               i_clk,
  input logic               i_reset,
  pcs_tx_gearbox_if.slave   bus
);

  localparam int unsigned InW  = DATA_WIDTH + HDR_WIDTH;
  localparam int unsigned BufW = 2 * DATA_WIDTH + HDR_WIDTH;
  localparam int unsigned CatW = BufW + InW;
  localparam int unsigned CntW = 7;
  localparam logic [5:0]  SeqLast = 6'd32;

  typedef enum logic {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [5:0]            seq_q, seq_d;
  logic                  half_q, half_d;
  logic                  pause_q, pause_d;
  logic [BufW-1:0]       buf_q, buf_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic                  active;
  logic [InW-1:0]        in_bits;
  logic [CntW-1:0]       in_len;
  logic [CatW-1:0]       cat;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      seq_q   <= '0;
      half_q  <= 1'b0;
      pause_q <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      half_q  <= half_d;
      pause_q <= pause_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    half_d  = half_q;
    pause_d = 1'b0;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    word_d  = '0;
    active  = 1'b0;
    in_bits = '0;
    in_len  = '0;
    cat     = '0;

    unique case (state_q)
      StIdle: begin
        // The first valid cycle is already the seq_cnt==0 first-half cycle.
        if (bus.i_valid) begin
          state_d = StRun;
          active  = 1'b1;
          in_bits = {bus.i_data, bus.i_hdr};
          in_len  = CntW'(InW);
          half_d  = 1'b1;
          seq_d   = 6'd1;
        end
      end
      StRun: begin
        active = 1'b1;
        seq_d  = (seq_q == SeqLast) ? 6'd0 : seq_q + 6'd1;
        // Pause cycles take no input; missing input is replaced by zeros.
        if (!pause_q) begin
          half_d = ~half_q;
          if (!half_q) begin
            in_bits = bus.i_valid ? {bus.i_data, bus.i_hdr} : '0;
            in_len  = CntW'(InW);
          end else begin
            in_bits = bus.i_valid ? InW'(bus.i_data) : '0;
            in_len  = CntW'(DATA_WIDTH);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (active) begin
      cat     = CatW'(buf_q) | (CatW'(in_bits) << cnt_q);
      word_d  = cat[DATA_WIDTH-1:0];
      buf_d   = BufW'(cat >> DATA_WIDTH);
      cnt_d   = cnt_q + in_len - CntW'(DATA_WIDTH);
      pause_d = (seq_d == SeqLast);
    end
  end

  assign bus.o_gearbox_data = word_q;
  assign bus.o_pause        = pause_q;

`ifdef PCS_TX_GBX_ERR_FLAGS_EN
  logic underflow_q, overrun_q;
  logic underflow_evt, overrun_evt;

  assign underflow_evt = (state_q == StRun) && !pause_q && !bus.i_valid;
  assign overrun_evt   = (state_q == StRun) && pause_q && bus.i_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      underflow_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      underflow_q <= underflow_q | underflow_evt;
      overrun_q   <= overrun_q | overrun_evt;
    end
  end

  assign bus.o_err_underflow = underflow_q;
  assign bus.o_err_overrun   = overrun_q;
`else
  assign bus.o_err_underflow = 1'b0;
  assign bus.o_err_overrun   = 1'b0;
`endif

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// Directed/random bench for pcs_tx_gearbox against a bit-queue model of the 66b stream.
module tb_pcs_tx_gearbox;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  pcs_tx_gearbox_if #(.DATA_WIDTH(32), .HDR_WIDTH(2)) bus ();

  pcs_tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: serialized bit stream queue, cycle position since first valid, half phase.
  bit          mq[$];
  bit          m_run;
  int          m_pos;
  bit          m_half;
  bit          m_uf;
  bit          m_of;
  logic [31:0] m_word;

  function automatic logic exp_flag(input bit f);
`ifdef PCS_TX_GBX_ERR_FLAGS_EN
    return f;
`else
    return 1'b0 & f;
`endif
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_pos = 0; m_half = 0; m_uf = 0; m_of = 0; m_word = '0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] h, input logic [31:0] d);
    if (!m_run && !v) begin
      m_word = '0;
      return;
    end
    if (!m_run) begin
      m_run = 1; m_pos = 0; m_half = 0;
    end
    if (m_pos == 32) begin
      if (v) m_of = 1;
    end else begin
      if (!v) begin
        m_uf = 1; h = 2'b00; d = '0;
      end
      if (!m_half) begin
        mq.push_back(h[0]);
        mq.push_back(h[1]);
      end
      for (int i = 0; i < 32; i++) mq.push_back(d[i]);
      m_half = !m_half;
    end
    for (int i = 0; i < 32; i++) m_word[i] = (mq.size() > 0) ? mq.pop_front() : 1'bx;
    m_pos = (m_pos + 1) % 33;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cycle(input bit v, input logic [1:0] h, input logic [31:0] d);
    check1("pause", bus.o_pause, m_run && (m_pos == 32));
    bus.i_valid = v;
    bus.i_hdr   = h;
    bus.i_data  = d;
    model_step(v, h, d);
    @(posedge clk);
    #1;
    check32("word", bus.o_gearbox_data, m_word);
    check1("underflow", bus.o_err_underflow, exp_flag(m_uf));
    check1("overrun", bus.o_err_overrun, exp_flag(m_of));
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_word"}, bus.o_gearbox_data, 32'h0);
    check1({tag, "_pause"}, bus.o_pause, 1'b0);
    check1({tag, "_uf"}, bus.o_err_underflow, 1'b0);
    check1({tag, "_of"}, bus.o_err_overrun, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_hdr   = '0;
    bus.i_data  = '0;
    #1;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Upstream honours o_pause; optionally drops valid or forces it at given positions.
  task automatic run(input int n, input int drop_pos, input int force_pos);
    bit v;
    for (int i = 0; i < n; i++) begin
      v = !bus.o_pause;
      if (m_run && m_pos == drop_pos) v = 1'b0;
      if (m_run && m_pos == force_pos) v = 1'b1;
      cycle(v, 2'($urandom_range(1, 2)), $urandom);
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_hdr   = '0;
    bus.i_data  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst = 1'b0;
    @(negedge clk);

    // Idle cycles produce nothing.
    cycle(1'b0, 2'b00, 32'h0);
    cycle(1'b0, 2'b00, 32'h0);

    // Single block framing.
    cycle(1'b1, 2'b10, 32'h0000_0000);
    check32("single_lo", bus.o_gearbox_data, 32'h0000_0002);
    cycle(1'b1, 2'b10, 32'hFFFF_FFFF);
    check32("single_hi", bus.o_gearbox_data, 32'hFFFF_FFFC);

    // Continuous traffic over three-plus periods.
    do_reset();
    run(110, -1, -1);

    // Residue drain after 16 all-ones blocks.
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1'b1, 2'b01, 32'hFFFF_FFFF);
    check1("drain_pause", bus.o_pause, 1'b1);
    cycle(1'b0, 2'b00, 32'h0);
    check32("drain_word", bus.o_gearbox_data, 32'hFFFF_FFFF);
    cycle(1'b1, 2'b10, 32'h0000_0000);
    check32("post_drain", bus.o_gearbox_data, 32'h0000_0002);

    // Underflow at seq 5, then keep running across the next pause.
    do_reset();
    run(40, 5, -1);
    check1("uf_sticky", bus.o_err_underflow, exp_flag(1'b1));

    // Overrun during pause.
    do_reset();
    run(45, -1, 32);
    check1("of_sticky", bus.o_err_overrun, exp_flag(1'b1));

    // Reset mid-period, then restart.
    do_reset();
    run(20, -1, -1);
    do_reset();
    cycle(1'b1, 2'b10, 32'h0000_0000);
    check32("restart_lo", bus.o_gearbox_data, 32'h0000_0002);
    cycle(1'b1, 2'b10, 32'hFFFF_FFFF);
    check32("restart_hi", bus.o_gearbox_data, 32'hFFFF_FFFC);
    run(40, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pcs_tx_gearbox.md
PCS_TX_GEARBOX -- requirements
Module: pcs_tx_gearbox

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 The block SHALL have a parameter DATA_WIDTH, default 32: width of the input data and output words (only 32 supported).
REQ-003 The block SHALL have a parameter HDR_WIDTH, default 2: width of the 64b/66b sync header.
REQ-004 i_clk  input  1  SHALL be the single clock for all logic.
REQ-005 i_reset  input  1  SHALL be the asynchronous active-high reset.
REQ-006 i_data  input  32  SHALL carry an encoded block half: bits 31:0 first, bits 63:32 second.
REQ-007 i_hdr  input  2  SHALL carry the sync header, sampled on first-half cycles only.
REQ-008 i_valid  input  1  SHALL qualify i_data/i_hdr.
REQ-009 o_pause  output  1  SHALL, when high, require upstream to hold i_valid low in that same cycle.
REQ-010 o_gearbox_data  output  32  SHALL be the word to the GTY transceiver, bit 0 transmitted first.
REQ-011 o_err_underflow  output  1  SHALL be a sticky flag: valid low in a RUN non-pause cycle.
REQ-012 o_err_overrun  output  1  SHALL be a sticky flag: valid high while o_pause is high.

Function
REQ-013 The state machine SHALL have two states, IDLE and RUN; reset SHALL enter IDLE.
REQ-014 In IDLE, outputs SHALL be 0, o_pause 0 and the half toggle 0; the first i_valid=1 SHALL move the block to RUN with seq_cnt=0 in that cycle.
REQ-015 In RUN, the 6-bit seq_cnt SHALL increment every cycle and wrap 32->0 (33-cycle period).
REQ-016 o_pause SHALL be high exactly in RUN cycles with seq_cnt==32 (registered, not combinational from i_valid).
REQ-017 The serialized stream order per block SHALL be hdr[0], hdr[1], block bit 0 ... block bit 63.
REQ-018 The half toggle SHALL flip on every RUN non-pause cycle: first half appends hdr + i_data (34 bits), second half appends i_data (32 bits).
REQ-019 Each RUN cycle SHALL emit the oldest 32 buffered bits on o_gearbox_data on the next clock edge (latency 1 cycle); the residue buffer SHALL be no smaller than 66 bits.
REQ-020 Residue SHALL grow 2 bits per block, reach 32 bits at seq_cnt==32, and the pause cycle SHALL drain it to 0.
REQ-021 On underflow (RUN, non-pause, i_valid=0), 32 zero bits (plus a 00 header on a first half) SHALL be substituted, the half toggle SHALL still flip, and o_err_underflow SHALL be set.
REQ-022 On overrun (i_valid=1 during pause), the input SHALL be dropped, the half toggle SHALL be unchanged, and o_err_overrun SHALL be set.
REQ-023 Sticky flags SHALL clear only on reset.

Reset
REQ-024 Reset SHALL clear o_gearbox_data, o_pause, seq_cnt, the half toggle, the residue buffer and its count, and both flags to 0, and enter IDLE.
REQ-025 Reset asserted mid-operation SHALL discard buffered bits immediately; after release the block SHALL restart as after power-on.

Configuration
REQ-026 The macro PCS_TX_GBX_ERR_FLAGS_EN SHALL, when defined, include the underflow/overrun detection logic.
REQ-027 Without PCS_TX_GBX_ERR_FLAGS_EN, both error ports SHALL remain present, be tied to 0, and data-path behaviour SHALL be unchanged.

Verification
REQ-028 Single block (reset, then hdr=2'b10, lo=0x00000000, hi=0xFFFFFFFF) -> o_gearbox_data=0x00000002 then 0xFFFFFFFC.
REQ-029 Continuous valid, honoured pause -> o_pause high at cycles 32, 65, 98 after the first valid; the output bitstream equals the 66-bit serialized blocks in order with no gaps.
REQ-030 Pause cycle after 16 blocks of all-ones data, hdr=2'b01 -> the pause-cycle output drains the 32 residual bits exactly; residue count = 0 afterwards.
REQ-031 i_valid=0 at seq_cnt=5 -> o_err_underflow=1 (sticky); the substituted 32 bits are zero; the period stays 33 cycles.
REQ-032 i_valid=1 at seq_cnt=32 -> o_err_overrun=1, the word is dropped, and the following output is unaffected; with the macro undefined, both flags stay 0.
REQ-033 Reset at seq_cnt=20 -> all outputs are 0 next cycle, IDLE entered; the next valid restarts with seq_cnt=0 and the first output matches REQ-028 framing.
